// File: rtl/trade_pkg.sv
// Shared types and default sizing for the trade scheduler.
// Optional watchdog is enabled by defining TRADE_SCHED_TIMEOUT_EN.
package trade_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HALT  = 2'd3
    } sched_state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_CNT_W          = 8;
    localparam int DEF_TRADE_LIMIT    = 99;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // Next round-robin start position after a grant to idx.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr,
// wrapping around the request vector.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         win_onehot,
    output logic [$clog2(NUM_REQ)-1:0] win_idx,
    output logic                       any_req
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] w_pos;
    logic             w_found;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        w_found    = 1'b0;
        w_pos      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pos = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!w_found && req[w_pos]) begin
                win_onehot[w_pos] = 1'b1;
                win_idx           = w_pos;
                w_found           = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/trade_scheduler.sv
// Round-robin sharing of the match engine with a session trade budget.
// Define TRADE_SCHED_TIMEOUT_EN to add the WAIT-state watchdog.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | sample requests; arbitrate on the previous IDLE sample
// ST_ISSUE | grant/eng_start asserted for one cycle
// ST_WAIT  | grant held until match_signal (or watchdog expiry)
// ST_HALT  | budget exhausted; only clear_halt leaves
module trade_scheduler
    import trade_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TRADE_LIMIT    = DEF_TRADE_LIMIT,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable_count,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       match_signal,
    input  logic                       match_ok,
    input  logic                       clear_halt,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       eng_start,
    output logic [$clog2(NUM_REQ)-1:0] eng_id,
    output logic                       busy,
    output logic [CNT_W-1:0]           trade_count,
    output logic                       halt_signal,
    output logic                       timeout_pulse
);

    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_t     r_state, w_state_n;
    logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_n;
    logic [NUM_REQ-1:0] r_req_smp;
    logic             r_en_smp;
    logic             r_smp_vld;

    logic [NUM_REQ-1:0] r_grant, w_grant_n;
    logic             r_eng_start, w_eng_start_n;
    logic [IDX_W-1:0] r_eng_id, w_eng_id_n;
    logic             r_busy, w_busy_n;
    logic [CNT_W-1:0] r_count, w_count_n, w_count_inc;
    logic             r_halt, w_halt_n;
    logic             r_timeout, w_timeout_n;

    logic [NUM_REQ-1:0] w_win_onehot;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_any_req;
    logic             w_wd_tc;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (r_req_smp),
        .rr_ptr     (r_rr_ptr),
        .win_onehot (w_win_onehot),
        .win_idx    (w_win_idx),
        .any_req    (w_any_req)
    );

    assign w_count_inc = r_count + 1'b1;

    always_comb begin
        w_state_n     = r_state;
        w_rr_ptr_n    = r_rr_ptr;
        w_grant_n     = r_grant;
        w_eng_start_n = 1'b0;
        w_eng_id_n    = r_eng_id;
        w_busy_n      = r_busy;
        w_count_n     = r_count;
        w_halt_n      = r_halt;
        w_timeout_n   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_smp_vld && r_en_smp && !r_halt && w_any_req) begin
                    w_state_n     = ST_ISSUE;
                    w_grant_n     = w_win_onehot;
                    w_eng_id_n    = w_win_idx;
                    w_eng_start_n = 1'b1;
                    w_busy_n      = 1'b1;
                    w_rr_ptr_n    = (w_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
                end
            end
            ST_ISSUE: begin
                w_state_n = ST_WAIT;
            end
            ST_WAIT: begin
                // A match arriving on the watchdog limit cycle takes priority.
                if (match_signal) begin
                    w_state_n  = ST_IDLE;
                    w_grant_n  = '0;
                    w_eng_id_n = '0;
                    w_busy_n   = 1'b0;
                    if (match_ok) begin
                        w_count_n = w_count_inc;
                        if (w_count_inc == CNT_W'(TRADE_LIMIT)) begin
                            w_state_n = ST_HALT;
                            w_halt_n  = 1'b1;
                        end
                    end
                end else if (w_wd_tc) begin
                    w_state_n   = ST_IDLE;
                    w_grant_n   = '0;
                    w_eng_id_n  = '0;
                    w_busy_n    = 1'b0;
                    w_timeout_n = 1'b1;
                end
            end
            ST_HALT: begin
                if (clear_halt) begin
                    w_state_n = ST_IDLE;
                    w_count_n = '0;
                    w_halt_n  = 1'b0;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_req_smp   <= '0;
            r_en_smp    <= 1'b0;
            r_smp_vld   <= 1'b0;
            r_grant     <= '0;
            r_eng_start <= 1'b0;
            r_eng_id    <= '0;
            r_busy      <= 1'b0;
            r_count     <= '0;
            r_halt      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_rr_ptr    <= w_rr_ptr_n;
            r_grant     <= w_grant_n;
            r_eng_start <= w_eng_start_n;
            r_eng_id    <= w_eng_id_n;
            r_busy      <= w_busy_n;
            r_count     <= w_count_n;
            r_halt      <= w_halt_n;
            r_timeout   <= w_timeout_n;
            // The sample taken on one IDLE edge is arbitrated on the next;
            // a fresh IDLE visit needs one sampling edge before a grant.
            if (r_state == ST_IDLE) begin
                r_req_smp <= req;
                r_en_smp  <= enable_count;
                r_smp_vld <= 1'b1;
            end else begin
                r_smp_vld <= 1'b0;
            end
        end
    end

`ifdef TRADE_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wdog;

    // Loaded while leaving ISSUE so terminal count lands TIMEOUT_CYCLES edges into WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_wdog <= WD_W'(TIMEOUT_CYCLES - 1);
        end else if (r_state == ST_WAIT && r_wdog != '0) begin
            r_wdog <= r_wdog - 1'b1;
        end
    end

    assign w_wd_tc = (r_state == ST_WAIT) && (r_wdog == '0);
`else
    logic w_unused_cfg;

    assign w_wd_tc      = 1'b0;
    assign w_unused_cfg = ^TIMEOUT_CYCLES;
`endif

    assign grant         = r_grant;
    assign eng_start     = r_eng_start;
    assign eng_id        = r_eng_id;
    assign busy          = r_busy;
    assign trade_count   = r_count;
    assign halt_signal   = r_halt;
    assign timeout_pulse = r_timeout;

endmodule

// File: doc/trade_scheduler.md
# trade_scheduler

Sequences the trade-match engine and shares it among up to NUM_REQ order sources, with a round-robin arbiter and a single-outstanding-transaction FSM. It tallies completed trades against a session budget and halts all issue when the budget is reached. It sits between the order-source front ends and the match engine, and supplies trade_count/halt_signal to the display and status logic.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- CNT_W, 8, trade_count width
- TRADE_LIMIT, 99, trade budget; must be less than 2**CNT_W
- TIMEOUT_CYCLES, 1024, watchdog limit while waiting for the engine (used only with the macro)
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- enable_count  input  1  permits new arbitration when high
- req  input  NUM_REQ  per-source request levels
- match_signal  input  1  engine completion pulse, one cycle
- match_ok  input  1  qualifies match_signal; 1 means a trade was executed
- clear_halt  input  1  one-cycle pulse that leaves HALT
- grant  output  NUM_REQ  one-hot owner of the engine
- eng_start  output  1  one-cycle issue pulse to the engine
- eng_id  output  $clog2(NUM_REQ)  index of the granted source
- busy  output  1  high in ISSUE and WAIT
- trade_count  output  CNT_W  executed trades this session
- halt_signal  output  1  budget exhausted
- timeout_pulse  output  1  watchdog abort pulse (tied 0 without the macro)

## Operation
- States: IDLE, ISSUE, WAIT, HALT.
- IDLE: when enable_count=1, halt_signal=0 and req!=0, pick the winner by round-robin starting at pointer rr_ptr, then go to ISSUE. Otherwise stay in IDLE.
- On grant: grant is one-hot, eng_id is the winner index, rr_ptr becomes (winner+1) mod NUM_REQ.
- ISSUE: eng_start=1 for exactly one cycle, then go to WAIT.
- WAIT: hold grant and eng_id. On match_signal, go to IDLE and clear grant.
  - If match_ok=1, trade_count increments.
  - If the new count equals TRADE_LIMIT, go to HALT instead of IDLE and set halt_signal.
- HALT: no issue. clear_halt sets trade_count to 0, clears halt_signal and returns to IDLE. clear_halt is ignored in every other state.
- Requests are sampled only in IDLE. Deasserting req during ISSUE or WAIT does not abort the transaction.
- Deasserting enable_count mid-transaction lets the current transaction complete. It only blocks the next arbitration.
- match_signal outside WAIT is ignored and has no effect on the count.
- trade_count never exceeds TRADE_LIMIT and never wraps.

## Timing
- Reset (reset=0): state=IDLE, rr_ptr=0, and every output is 0 (grant, eng_start, eng_id, busy, trade_count, halt_signal, timeout_pulse).
- All outputs are registered.
- Request latency: req seen in IDLE at edge N gives grant and eng_start high after edge N+1; WAIT begins after edge N+2.
- Completion: match_signal high at edge M gives trade_count, halt_signal, state and grant=0 updated after edge M.
  - The earliest re-arbitration is sampled at edge M+1.
- Back-to-back throughput: at most one transaction per 3 cycles plus the engine latency.
- The final trade and halt_signal assert on the same edge.
- Reset mid-transaction: the abort is immediate, with no eng_start and no count change. The engine is reset by the same reset.

## Configuration
- TRADE_SCHED_TIMEOUT_EN defined: a watchdog counter runs in WAIT and clears on entry to WAIT.
  - When it reaches TIMEOUT_CYCLES with no match_signal: timeout_pulse=1 for one cycle, state goes to IDLE, grant clears, trade_count is unchanged.
  - If match_signal arrives on the limit cycle, the match wins.
- Undefined: no watchdog; WAIT persists until match_signal; timeout_pulse is tied 0.

## Structure
- Package trade_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/HALT);
  - the default NUM_REQ, TRADE_LIMIT and TIMEOUT_CYCLES constants;
  - the sched_state_t typedef.
- Sub-module rr_arbiter is combinational. Inputs: req and rr_ptr. Outputs: one-hot winner, winner index, any_req.
- trade_scheduler owns the FSM, rr_ptr, trade_count and the watchdog.

## Test plan
- Single source: req=4'b0001, then match_signal with match_ok=1.
  - Required: eng_start is one cycle, grant=0001 and eng_id=0 during WAIT, trade_count=1.
- Fairness: req=4'b1111 held, every match completes.
  - Required: grant order 0,1,2,3,0; rr_ptr wraps from 3 to 0.
- Rejected match: match_signal with match_ok=0.
  - Required: trade_count unchanged; return to IDLE; next grant goes to the next source in order.
- Budget:
  - 99 successful trades: on the 99th completion trade_count=99 and halt_signal=1 on the same edge.
  - Further req: no eng_start.
  - clear_halt: trade_count=0, halt_signal=0.
- Stray and aborting events:
  - match_signal in IDLE: ignored.
  - reset low during WAIT: all outputs return to 0 immediately.
  - enable_count=0 during WAIT: the transaction completes and no new grant follows.
- With TRADE_SCHED_TIMEOUT_EN, no match_signal for TIMEOUT_CYCLES:
  - Required: timeout_pulse for 1 cycle, grant=0, count unchanged.
  - Match on the limit cycle: counted, no timeout.
